// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between NUM_REQ requesters.
// Optional packet lock: define UART_ARB_LOCK_EN to keep a requester's multi-byte packet contiguous.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                   clock50,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*8-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic                   tx_err
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t               state_q;
    logic [PTR_W-1:0]     ptr_q;
    logic [PTR_W-1:0]     win_q;
    logic [7:0]           cnt_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [NUM_REQ-1:0]   ready_q;
    logic                 start_q;
    logic [7:0]           data_q;
    logic                 err_q;

    logic [NUM_REQ-1:0]   elig;
    logic [NUM_REQ-1:0]   win_oh;
    logic [PTR_W-1:0]     win_idx;
    logic                 win_found;
    logic [7:0]           win_data;
    logic [PTR_W-1:0]     ptr_d;

`ifdef UART_ARB_LOCK_EN
    logic                 lock_q;
    logic                 last_q;
    logic [NUM_REQ-1:0]   own_mask;

    always_comb begin
        own_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            own_mask[i] = (win_q == PTR_W'(i));
        end
    end
`else
    logic unused_last;
    assign unused_last = ^req_last;
`endif

    // Search from ptr upward; iterating in reverse lets the closest index win.
    always_comb begin
        int idx;
        idx       = 0;
        elig      = req_valid;
`ifdef UART_ARB_LOCK_EN
        if (lock_q) begin
            elig = req_valid & own_mask;
        end
`endif
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (elig[idx[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = idx[PTR_W-1:0];
            end
        end
        win_oh   = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_oh[i] = win_found && (win_idx == PTR_W'(i));
            if (win_oh[i]) begin
                win_data = req_data[8*i +: 8];
            end
        end
        ptr_d = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + PTR_W'(1);
    end

    always_ff @(posedge clock50) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            ready_q <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            lock_q  <= 1'b0;
            last_q  <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            ready_q <= '0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!tx_busy && win_found) begin
                        grant_q <= win_oh;
                        ready_q <= win_oh;
                        start_q <= 1'b1;
                        data_q  <= win_data;
                        win_q   <= win_idx;
`ifdef UART_ARB_LOCK_EN
                        last_q  <= req_last[win_idx];
`endif
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    cnt_q   <= 8'(BUSY_TIMEOUT);
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_q <= S_WAIT_DONE;
                    end else if (cnt_q <= 8'd1) begin
                        err_q   <= 1'b1;
                        grant_q <= '0;
                        ptr_q   <= ptr_d;
`ifdef UART_ARB_LOCK_EN
                        lock_q  <= 1'b0;
`endif
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        grant_q <= '0;
                        state_q <= S_IDLE;
`ifdef UART_ARB_LOCK_EN
                        // A non-final byte keeps the owner; ptr only moves once the packet ends.
                        if (!last_q) begin
                            lock_q <= 1'b1;
                        end else begin
                            lock_q <= 1'b0;
                            ptr_q  <= ptr_d;
                        end
`else
                        ptr_q   <= ptr_d;
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready = ready_q;
    assign grant     = grant_q;
    assign tx_start  = start_q;
    assign tx_data   = data_q;
    assign tx_err    = err_q;

endmodule
